// File: rtl/uart_tx_fifo_pkg.sv
// ============================================================================
// Module : uart_tx_fifo_pkg
// Brief  : Shared UART transmitter definitions (FSM encoding, defaults, map).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  localparam int UART_CLKS_PER_BIT_DEFAULT = 217;  // 25 MHz / 115200 baud
  localparam int UART_DATA_BITS            = 8;
  localparam int UART_IO_ADDR_BIT          = 4;    // SOC I/O address bit selecting the UART

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo_sync_fifo.sv
// ============================================================================
// Module : uart_tx_fifo_sync_fifo
// Brief  : Synchronous FIFO with occupancy and registered full/empty flags.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wr_data,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic             full_q,   full_d;
  logic             empty_q,  empty_d;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Requests against a full/empty FIFO are ignored, never corrupt state.
  always_comb begin
    w_push_ok = i_push && !full_q;
    w_pop_ok  = i_pop  && !empty_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (w_push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({w_push_ok, w_pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == (AW+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) mem_q[wr_ptr_q] <= i_wr_data;
  end

  assign o_rd_data = mem_q[rd_ptr_q];
  assign o_level   = count_q;
  assign o_full    = full_q;
  assign o_empty   = empty_q;

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module : uart_tx_fifo
// Brief  : Buffered 8N1 UART transmitter driving the SOC TXD pad.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          WR_EN,
  input  logic [7:0]                    WR_DATA,
  output logic                          BUSY,
  output logic                          IDLE,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
  output logic                          TXD
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  tx_state_t        state_q,   state_d;
  logic [CNT_W-1:0] baud_q,    baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q,   shift_d;
  logic             txd_q,     txd_d;
  logic             w_pop;
  logic             w_bit_end;
  logic [7:0]       w_head;
  logic             w_full;
  logic             w_empty;

  uart_tx_fifo_sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RESET),
    .i_push    (WR_EN),
    .i_pop     (w_pop),
    .i_wr_data (WR_DATA),
    .o_rd_data (w_head),
    .o_level   (LEVEL),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    w_pop     = 1'b0;
    w_bit_end = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
    if (state_q != S_IDLE) baud_d = w_bit_end ? '0 : baud_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!w_empty) begin
          w_pop   = 1'b1;
          shift_d = w_head;
          state_d = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Chain straight into the next start bit when more data is queued.
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop   = 1'b1;
            shift_d = w_head;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The line is registered from the current state, so it trails the FSM by one cycle.
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_q[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
    end
  end

  assign TXD  = txd_q;
  assign BUSY = w_full;
  assign IDLE = w_empty && (state_q == S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module : tb_uart_tx_fifo
// Brief  : Directed self-checking bench for uart_tx_fifo (CLKS_PER_BIT=4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       WR_EN = 1'b0;
  logic [7:0] WR_DATA = 8'h00;
  logic       BUSY;
  logic       IDLE;
  logic [2:0] LEVEL;
  logic       TXD;

  int chk_cnt = 0;
  int err_cnt = 0;

  logic [8:0] rx_q [$];

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .WR_EN   (WR_EN),
    .WR_DATA (WR_DATA),
    .BUSY    (BUSY),
    .IDLE    (IDLE),
    .LEVEL   (LEVEL),
    .TXD     (TXD)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    WR_EN   = 1'b1;
    WR_DATA = d;
    @(posedge CLK);
    #1;
    WR_EN   = 1'b0;
  endtask

  task automatic check_rx(input string tag, input logic [7:0] exp_bytes [$]);
    check({tag, "_count"}, rx_q.size(), exp_bytes.size());
    for (int i = 0; i < exp_bytes.size(); i++) begin
      if (i < rx_q.size())
        check($sformatf("%s_byte%0d", tag, i), rx_q[i], {1'b1, exp_bytes[i]});
    end
  endtask

  // Line receiver: samples mid-bit, flags bad start/stop in bit 8 of each entry.
  initial begin
    logic       ok;
    logic [7:0] b;
    forever begin
      @(negedge CLK);
      if (TXD === 1'b0) begin
        ok = 1'b1;
        repeat (CPB/2) @(negedge CLK);
        if (TXD !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge CLK);
          b[i] = TXD;
        end
        repeat (CPB) @(negedge CLK);
        if (TXD !== 1'b1) ok = 1'b0;
        rx_q.push_back({ok, b});
      end
    end
  end

  initial begin
    logic [7:0] a5;
    logic       exp_txd;
    logic [7:0] exp_bytes [$];

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_txd",   TXD,   1);
      check("rst_busy",  BUSY,  0);
      check("rst_idle",  IDLE,  1);
      check("rst_level", LEVEL, 0);
    end
    RESET = 1'b0;
    tick(2);

    // Single byte, cycle-exact waveform
    rx_q.delete();
    a5 = 8'hA5;
    wr(a5);
    for (int k = 0; k < 44; k++) begin
      if (k > 0) tick(1);
      if (k < 2)       exp_txd = 1'b1;
      else if (k < 6)  exp_txd = 1'b0;
      else if (k < 38) exp_txd = a5[(k-6)/4];
      else             exp_txd = 1'b1;
      check($sformatf("single_txd_k%0d", k), TXD, exp_txd);
      if (k == 0)  check("single_level_push", LEVEL, 1);
      if (k == 1)  check("single_level_pop",  LEVEL, 0);
      if (k == 20) check("single_idle_mid",   IDLE,  0);
      if (k == 42) check("single_idle_end",   IDLE,  1);
    end
    exp_bytes = '{8'hA5};
    check_rx("single_rx", exp_bytes);

    // Back-to-back frames, no idle gap
    tick(5);
    rx_q.delete();
    wr(8'h55);
    wr(8'h0F);
    tick(40);
    check("b2b_stop1_txd",  TXD,  1);
    check("b2b_stop1_idle", IDLE, 0);
    tick(1);
    check("b2b_start2_txd", TXD,  0);
    tick(45);
    check("b2b_idle_end",   IDLE, 1);
    exp_bytes = '{8'h55, 8'h0F};
    check_rx("b2b_rx", exp_bytes);

    // Overflow: sixth byte dropped while full
    tick(5);
    rx_q.delete();
    wr(8'h01);
    wr(8'h02);
    check("ovf_level_after2", LEVEL, 1);
    wr(8'h03);
    wr(8'h04);
    check("ovf_busy_before_full", BUSY, 0);
    wr(8'h05);
    check("ovf_busy_full",  BUSY,  1);
    check("ovf_level_full", LEVEL, 4);
    wr(8'h06);
    check("ovf_level_drop", LEVEL, 4);
    check("ovf_busy_drop",  BUSY,  1);
    tick(5*40 + 10);
    check("ovf_idle_end",   IDLE,  1);
    check("ovf_level_end",  LEVEL, 0);
    exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    check_rx("ovf_rx", exp_bytes);

    // Push and pop in the same cycle as a stop bit ends
    tick(5);
    rx_q.delete();
    wr(8'h11);
    tick(1);
    wr(8'h22);
    check("pp_level_before", LEVEL, 1);
    tick(38);
    wr(8'h77);
    check("pp_level_same", LEVEL, 1);
    check("pp_busy_same",  BUSY,  0);
    tick(2*40 + 10);
    exp_bytes = '{8'h11, 8'h22, 8'h77};
    check_rx("pp_rx", exp_bytes);

    // Reset during bit 3 of 0xFF, then a clean frame
    tick(5);
    wr(8'hFF);
    tick(19);
    check("rstmid_idle_before", IDLE, 0);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    check("rstmid_txd",   TXD,   1);
    check("rstmid_level", LEVEL, 0);
    check("rstmid_idle",  IDLE,  1);
    check("rstmid_busy",  BUSY,  0);
    tick(50);
    rx_q.delete();
    wr(8'h3C);
    tick(1);
    check("rstmid_new_pre",   TXD, 1);
    tick(1);
    check("rstmid_new_start", TXD, 0);
    tick(45);
    exp_bytes = '{8'h3C};
    check_rx("rstmid_rx", exp_bytes);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire
